// File: rtl/cdb_arbiter.sv
// Common-data-bus producer: one small result FIFO per functional unit, with up to
// CDB_SIZE FIFO heads broadcast per cycle under a rotating (round-robin) priority.
module cdb_arbiter #(
    parameter int NUM_FU     = 6,
    parameter int CDB_SIZE   = 4,
    parameter int ROB_DEPTH  = 8,
    parameter int FIFO_DEPTH = 2,
    localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic [NUM_FU-1:0]                  fu_valid_i,
    output logic [NUM_FU-1:0]                  fu_ready_o,
    input  logic [NUM_FU-1:0][TAG_W-1:0]       fu_rob_tag_i,
    input  logic [NUM_FU-1:0][31:0]            fu_data_i,
    output logic [CDB_SIZE-1:0]                cdb_valid_o,
    output logic [CDB_SIZE-1:0][TAG_W-1:0]     rob_tag_o,
    output logic [CDB_SIZE-1:0][31:0]          data_out_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int RR_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int LANE_W = $clog2(CDB_SIZE + 1);
    localparam int LIDX_W = (CDB_SIZE > 1) ? $clog2(CDB_SIZE) : 1;

    logic [TAG_W-1:0] tag_mem_q  [NUM_FU][FIFO_DEPTH];
    logic [31:0]      data_mem_q [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q   [NUM_FU];
    logic [PTR_W-1:0] wr_ptr_d   [NUM_FU];
    logic [PTR_W-1:0] rd_ptr_q   [NUM_FU];
    logic [PTR_W-1:0] rd_ptr_d   [NUM_FU];
    logic [CNT_W-1:0] count_q    [NUM_FU];
    logic [CNT_W-1:0] count_d    [NUM_FU];
    logic [RR_W-1:0]  rr_ptr_q;
    logic [RR_W-1:0]  rr_ptr_d;
    logic [NUM_FU-1:0] ready;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] grant;

    // Ready comes from the registered count only, so a full FIFO never accepts
    // even when it is being popped in the same cycle.
    always_comb begin
        ready = '0;
        push  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            ready[i] = (count_q[i] < CNT_W'(FIFO_DEPTH));
            push[i]  = fu_valid_i[i] & ready[i] & ~flush_i & ~rst_i;
        end
    end

    assign fu_ready_o = ready;

    // Scan once around starting at rr_ptr; the k-th non-empty FIFO found drives lane k.
    always_comb begin
        logic [RR_W:0]   sum;
        logic [RR_W-1:0] idx;
        logic [RR_W-1:0] last;
        logic [LANE_W-1:0] lane;
        grant       = '0;
        cdb_valid_o = '0;
        rob_tag_o   = '0;
        data_out_o  = '0;
        rr_ptr_d    = rr_ptr_q;
        sum         = '0;
        idx         = '0;
        last        = '0;
        lane        = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            sum = {1'b0, rr_ptr_q} + (RR_W+1)'(j);
            if (sum >= (RR_W+1)'(NUM_FU)) begin
                sum = sum - (RR_W+1)'(NUM_FU);
            end
            idx = sum[RR_W-1:0];
            if (!rst_i && !flush_i && (count_q[idx] != '0) && (lane < LANE_W'(CDB_SIZE))) begin
                grant[idx]                      = 1'b1;
                cdb_valid_o[lane[LIDX_W-1:0]]   = 1'b1;
                rob_tag_o[lane[LIDX_W-1:0]]     = tag_mem_q[idx][rd_ptr_q[idx]];
                data_out_o[lane[LIDX_W-1:0]]    = data_mem_q[idx][rd_ptr_q[idx]];
                last                            = idx;
                lane                            = lane + 1'b1;
            end
        end
        if (lane != '0) begin
            rr_ptr_d = (last == RR_W'(NUM_FU - 1)) ? '0 : last + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(grant[i]);
            count_d[i]  = count_q[i] + CNT_W'(push[i]) - CNT_W'(grant[i]);
        end
    end

    // Flush clears the same control state as reset; stored payloads need no clearing.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                tag_mem_q[i][wr_ptr_q[i]]  <= fu_rob_tag_i[i];
                data_mem_q[i][wr_ptr_q[i]] <= fu_data_i[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and scoreboard-based checks for cdb_arbiter: reset, single result,
// oversubscription, round-robin wrap, flush, and sustained backpressure.
module tb_cdb_arbiter;

    localparam int NUM_FU = 6;
    localparam int CDB    = 4;

    typedef struct packed {
        logic [2:0]  tag;
        logic [31:0] data;
    } ent_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU-1:0]        fu_ready;
    logic [NUM_FU-1:0][2:0]   fu_tag;
    logic [NUM_FU-1:0][31:0]  fu_data;
    logic [CDB-1:0]           cdb_valid;
    logic [CDB-1:0][2:0]      rob_tag;
    logic [CDB-1:0][31:0]     data_out;

    int compared   = 0;
    int mismatched = 0;

    ent_t sb   [NUM_FU][$];
    ent_t pend [NUM_FU];

    cdb_arbiter #(
        .NUM_FU     (NUM_FU),
        .CDB_SIZE   (CDB),
        .ROB_DEPTH  (8),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .fu_valid_i   (fu_valid),
        .fu_ready_o   (fu_ready),
        .fu_rob_tag_i (fu_tag),
        .fu_data_i    (fu_data),
        .cdb_valid_o  (cdb_valid),
        .rob_tag_o    (rob_tag),
        .data_out_o   (data_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic ent_t new_entry(int i);
        ent_t e;
        e.tag  = 3'($urandom_range(0, 7));
        e.data = {3'(i), 29'($urandom)};
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; fu_valid = '0; fu_tag = '0; fu_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if (cdb_valid !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL reset_cdb_valid: got %b expected 0000", cdb_valid);
        end
        compared++;
        if (fu_ready !== 6'h3f) begin
            mismatched++; $display("[TB] FAIL reset_fu_ready: got %b expected 111111", fu_ready);
        end
        compared++;
        if (dut.rr_ptr_q !== 3'd0) begin
            mismatched++; $display("[TB] FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr_q);
        end
        compared++;
        if (rob_tag !== '0 || data_out !== '0) begin
            mismatched++; $display("[TB] FAIL reset_lanes: got tag %h data %h expected 0", rob_tag, data_out);
        end
    endtask

    task automatic test_single();
        fu_valid = 6'b000100; fu_tag[2] = 3'd3; fu_data[2] = 32'hDEADBEEF;
        tick();
        fu_valid = '0;
        compared++;
        if (cdb_valid !== 4'b0001) begin
            mismatched++; $display("[TB] FAIL single_valid: got %b expected 0001", cdb_valid);
        end
        compared++;
        if (rob_tag[0] !== 3'd3 || data_out[0] !== 32'hDEADBEEF) begin
            mismatched++; $display("[TB] FAIL single_lane0: got %0d/%h expected 3/deadbeef", rob_tag[0], data_out[0]);
        end
        compared++;
        if (rob_tag[3:1] !== '0 || data_out[3:1] !== '0) begin
            mismatched++; $display("[TB] FAIL single_unused: got %h/%h expected 0", rob_tag[3:1], data_out[3:1]);
        end
        tick();
        compared++;
        if (cdb_valid !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL single_after: got %b expected 0000", cdb_valid);
        end
    endtask

    task automatic test_oversub();
        rst = 1'b1; tick(); rst = 1'b0;
        fu_valid = 6'h3f;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_tag[i] = 3'(i); fu_data[i] = 32'h100 + i;
        end
        tick();
        fu_valid = '0;
        compared++;
        if (cdb_valid !== 4'b1111) begin
            mismatched++; $display("[TB] FAIL over_valid1: got %b expected 1111", cdb_valid);
        end
        for (int k = 0; k < CDB; k++) begin
            compared++;
            if (rob_tag[k] !== 3'(k) || data_out[k] !== 32'h100 + k) begin
                mismatched++; $display("[TB] FAIL over_lane%0d: got %0d/%h expected %0d/%h",
                                       k, rob_tag[k], data_out[k], k, 32'h100 + k);
            end
        end
        tick();
        compared++;
        if (cdb_valid !== 4'b0011) begin
            mismatched++; $display("[TB] FAIL over_valid2: got %b expected 0011", cdb_valid);
        end
        compared++;
        if (rob_tag[0] !== 3'd4 || rob_tag[1] !== 3'd5 || data_out[0] !== 32'h104 || data_out[1] !== 32'h105) begin
            mismatched++; $display("[TB] FAIL over_second: got %0d %0d %h %h expected 4 5 104 105",
                                   rob_tag[0], rob_tag[1], data_out[0], data_out[1]);
        end
        tick();
        compared++;
        if (dut.rr_ptr_q !== 3'd0 || cdb_valid !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL over_rr: got rr %0d valid %b expected 0 0000", dut.rr_ptr_q, cdb_valid);
        end
    endtask

    task automatic test_wrap();
        fu_valid = 6'b010000; fu_tag[4] = 3'd6; fu_data[4] = 32'hA4;
        tick();
        compared++;
        if (cdb_valid !== 4'b0001 || rob_tag[0] !== 3'd6) begin
            mismatched++; $display("[TB] FAIL wrap_fu4: got %b tag %0d expected 0001 tag 6", cdb_valid, rob_tag[0]);
        end
        fu_valid = 6'b100001;
        fu_tag[5] = 3'd7; fu_data[5] = 32'hA5;
        fu_tag[0] = 3'd1; fu_data[0] = 32'hA0;
        tick();
        fu_valid = '0;
        compared++;
        if (dut.rr_ptr_q !== 3'd5) begin
            mismatched++; $display("[TB] FAIL wrap_rr5: got %0d expected 5", dut.rr_ptr_q);
        end
        compared++;
        if (cdb_valid !== 4'b0011 || rob_tag[0] !== 3'd7 || data_out[0] !== 32'hA5 ||
            rob_tag[1] !== 3'd1 || data_out[1] !== 32'hA0) begin
            mismatched++; $display("[TB] FAIL wrap_lanes: got %b %0d/%h %0d/%h expected 0011 7/a5 1/a0",
                                   cdb_valid, rob_tag[0], data_out[0], rob_tag[1], data_out[1]);
        end
        tick();
        compared++;
        if (dut.rr_ptr_q !== 3'd1 || cdb_valid !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL wrap_rr1: got rr %0d valid %b expected 1 0000", dut.rr_ptr_q, cdb_valid);
        end
    endtask

    task automatic test_flush();
        fu_valid = 6'h3f;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_tag[i] = 3'(i); fu_data[i] = 32'hF0 + i;
        end
        tick();
        fu_valid = 6'b000010; fu_tag[1] = 3'd2; fu_data[1] = 32'hBAD1;
        flush = 1'b1;
        #1;
        compared++;
        if (cdb_valid !== 4'b0000 || fu_ready[1] !== 1'b1) begin
            mismatched++; $display("[TB] FAIL flush_same: got valid %b ready1 %b expected 0000 1", cdb_valid, fu_ready[1]);
        end
        tick();
        flush = 1'b0; fu_valid = '0;
        compared++;
        if (cdb_valid !== 4'b0000 || fu_ready !== 6'h3f || dut.rr_ptr_q !== 3'd0) begin
            mismatched++; $display("[TB] FAIL flush_next: got valid %b ready %b rr %0d expected 0000 111111 0",
                                   cdb_valid, fu_ready, dut.rr_ptr_q);
        end
        tick();
        compared++;
        if (cdb_valid !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL flush_discard: got %b expected 0000", cdb_valid);
        end
    endtask

    // Every FU offers a result every cycle; the top three data bits carry the FU id
    // so each broadcast can be matched against that FU's expected queue.
    task automatic test_backpressure();
        int waitc [NUM_FU];
        int maxwait   = 0;
        int first_low = -1;
        int n;
        logic [NUM_FU-1:0] ne, granted, exp_ready, acc;
        logic [3:0] exp_valid;
        logic [2:0] fu;
        ent_t got;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            waitc[i] = 0;
            pend[i]  = new_entry(i);
        end
        for (int c = 0; c < 230; c++) begin
            n = 0; ne = '0; exp_ready = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                ne[i]        = (sb[i].size() != 0);
                exp_ready[i] = (sb[i].size() < 2);
                if (ne[i]) n++;
            end
            if (n > CDB) n = CDB;
            exp_valid = 4'((1 << n) - 1);
            if (fu_ready !== 6'h3f && first_low < 0) first_low = c;
            compared++;
            if (fu_ready !== exp_ready) begin
                mismatched++; $display("[TB] FAIL bp_ready c%0d: got %b expected %b", c, fu_ready, exp_ready);
            end
            compared++;
            if (cdb_valid !== exp_valid) begin
                mismatched++; $display("[TB] FAIL bp_valid c%0d: got %b expected %b", c, cdb_valid, exp_valid);
            end
            granted = '0;
            for (int k = 0; k < CDB; k++) begin
                if (cdb_valid[k] === 1'b1) begin
                    fu = data_out[k][31:29];
                    compared++;
                    if (fu >= NUM_FU || granted[fu] || sb[fu].size() == 0) begin
                        mismatched++; $display("[TB] FAIL bp_source c%0d lane%0d: got fu %0d expected a distinct non-empty FU", c, k, fu);
                    end else begin
                        got = {rob_tag[k], data_out[k]};
                        if (got !== sb[fu][0]) begin
                            mismatched++; $display("[TB] FAIL bp_order c%0d lane%0d: got %h expected %h", c, k, got, sb[fu][0]);
                        end
                        void'(sb[fu].pop_front());
                        granted[fu] = 1'b1;
                    end
                end
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (ne[i] && !granted[i]) waitc[i]++;
                else waitc[i] = 0;
                if (waitc[i] > maxwait) maxwait = waitc[i];
            end
            acc = '0;
            if (c < 200) begin
                fu_valid = 6'h3f;
                for (int i = 0; i < NUM_FU; i++) begin
                    fu_tag[i]  = pend[i].tag;
                    fu_data[i] = pend[i].data;
                    acc[i]     = fu_ready[i];
                    if (acc[i]) sb[i].push_back(pend[i]);
                end
            end else begin
                fu_valid = '0;
            end
            tick();
            for (int i = 0; i < NUM_FU; i++) begin
                if (acc[i]) pend[i] = new_entry(i);
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            compared++;
            if (sb[i].size() != 0) begin
                mismatched++; $display("[TB] FAIL bp_drain fu%0d: got %0d left expected 0", i, sb[i].size());
            end
        end
        compared++;
        if (maxwait > 2) begin
            mismatched++; $display("[TB] FAIL bp_starve: got %0d cycles expected <= 2", maxwait);
        end
        compared++;
        if (first_low < 0 || first_low > 2) begin
            mismatched++; $display("[TB] FAIL bp_ready_drop: got cycle %0d expected 0..2", first_low);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_oversub();
        test_wrap();
        test_flush();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
